// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - integer register file with write-through read ports, writeback echo and retire counter
// x0 has no storage; reads of index 0 always return zero.
module reg_writeback #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec_stall_next,
  input  logic             exec_exception,
  input  logic             exec_is_reg_write,
  input  logic [4:0]       exec_reg_write_sel,
  input  logic [XLEN-1:0]  exec_result,
  input  logic             read_en,
  input  logic [4:0]       rs1_sel,
  input  logic [4:0]       rs2_sel,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             wb_valid,
  output logic [4:0]       wb_sel,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] retired_count
);

  logic [XLEN-1:0]  regs_q [1:31];
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_sel_q, wb_sel_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             commit;
  logic             write_fire;
  logic [XLEN-1:0]  rf_rd1, rf_rd2;

  assign commit     = !exec_stall_next && !exec_exception;
  assign write_fire = commit && exec_is_reg_write && (exec_reg_write_sel != 5'd0);

  // Mux-style lookup keeps index 0 from ever touching the array.
  always_comb begin
    rf_rd1 = '0;
    rf_rd2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (rs1_sel == 5'(i)) rf_rd1 = regs_q[i];
      if (rs2_sel == 5'(i)) rf_rd2 = regs_q[i];
    end
  end

  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    wb_valid_d = write_fire;
    wb_sel_d   = wb_sel_q;
    wb_data_d  = wb_data_q;
    cnt_d      = cnt_q;
    if (read_en) begin
      // write_fire already excludes index 0, so the bypass never leaks into x0
      if (write_fire && (rs1_sel == exec_reg_write_sel)) rs1_data_d = exec_result;
      else                                              rs1_data_d = rf_rd1;
      if (write_fire && (rs2_sel == exec_reg_write_sel)) rs2_data_d = exec_result;
      else                                              rs2_data_d = rf_rd2;
    end
    if (write_fire) begin
      wb_sel_d  = exec_reg_write_sel;
      wb_data_d = exec_result;
    end
    if (commit) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (write_fire && (exec_reg_write_sel == 5'(i))) regs_q[i] <= exec_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      wb_valid_q <= 1'b0;
      wb_sel_q   <= 5'd0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      wb_valid_q <= wb_valid_d;
      wb_sel_q   <= wb_sel_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rs1_data      = rs1_data_q;
  assign rs2_data      = rs2_data_q;
  assign wb_valid      = wb_valid_q;
  assign wb_sel        = wb_sel_q;
  assign wb_data       = wb_data_q;
  assign retired_count = cnt_q;

endmodule
